// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared states, counter width and default timings for btn_event_gen
package btn_pkg;

  localparam int CNT_W         = 12;
  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } btn_state_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registers the button level and flags its rising/falling edges
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic pb_q;

  // Reset to "pressed" so a button held through reset never looks like a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_q <= 1'b1;
    end else begin
      pb_q <= din;
    end
  end

  assign rise = din & ~pb_q;
  assign fall = ~din & pb_q;

endmodule

// File: rtl/btn_event_gen.sv
// rtl/btn_event_gen.sv - press/click/long/repeat/release event generator for one debounced button
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF
) (
  input  logic       clk_1ms,
  input  logic       rst,
  input  logic       pbreg,
  output logic       press_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  logic             rise, fall;
  btn_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       count_d;
  logic             press_d, click_d, long_d, repeat_d, release_d;

  edge_detect u_edge (
    .clk  (clk_1ms),
    .rst  (rst),
    .din  (pbreg),
    .rise (rise),
    .fall (fall)
  );

  // A release seen on the threshold cycle is checked first, so it always wins.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    count_d   = press_count;
    press_d   = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_SHORT;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = press_count + 8'd1;
        end
      end
      ST_SHORT: begin
        if (fall) begin
          click_d   = 1'b1;
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (pbreg) begin
          if (cnt == LONG_LAST) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_LONG;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_LONG: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (pbreg) begin
          if (cnt == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_count   <= 8'd0;
      press_pulse   <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      press_count   <= count_d;
      press_pulse   <= press_d;
      click_pulse   <= click_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      release_pulse <= release_d;
      held          <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb/tb_btn_event_gen.sv - table-driven scoreboard bench for btn_event_gen
module tb_btn_event_gen;

    localparam int LONG = 10;
    localparam int REP  = 4;

    logic       clk_1ms = 1'b0;
    logic       rst     = 1'b1;
    logic       pbreg   = 1'b0;
    logic       press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;
    logic [7:0] press_count;

    typedef struct {
        logic       rst;
        logic       pb;
        logic [5:0] flags;
        logic [7:0] cnt;
        string      tag;
    } vec_t;

    vec_t        tbl[$];
    logic [13:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  model_cnt = 8'd0;
    logic        done = 1'b0;

    always #5 clk_1ms = ~clk_1ms;

    btn_event_gen #(.LONG_MS(LONG), .REPEAT_MS(REP)) dut (
        .clk_1ms       (clk_1ms),
        .rst           (rst),
        .pbreg         (pbreg),
        .press_pulse   (press_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .release_pulse (release_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    task automatic add(input logic r, input logic p, input logic [5:0] f,
                       input logic [7:0] c, input string t);
        vec_t v;
        v.rst = r; v.pb = p; v.flags = f; v.cnt = c; v.tag = t;
        tbl.push_back(v);
    endtask

    task automatic add_press(input int n, input string t);
        for (int i = 0; i < n; i++) begin
            logic [5:0] f;
            f = 6'b000001;
            if (i == 0) begin
                model_cnt = model_cnt + 8'd1;
                f[5] = 1'b1;
            end
            if (i == LONG) f[3] = 1'b1;
            if (i > LONG && ((i - LONG) % REP) == 0) f[2] = 1'b1;
            add(1'b0, 1'b1, f, model_cnt, t);
        end
    endtask

    task automatic add_hold(input int n, input string t);
        logic [5:0] f;
        add_press(n, t);
        f = 6'b000010;
        f[4] = (n <= LONG);
        add(1'b0, 1'b0, f, model_cnt, t);
        add(1'b0, 1'b0, 6'b0, model_cnt, t);
    endtask

    initial begin
        #200000;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: stimulus did not complete, %0d vectors applied", n_vec);
            $display("== TEST FAILED ==");
            $finish;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 6'b0, 8'd0, "reset");
        model_cnt = 8'd0;
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 6'b0, 8'd0, "rst_rel_low");
        add_hold(5, "short_click");
        add_hold(25, "long_hold");
        add_hold(10, "boundary");
        add_hold(11, "just_long");

        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 6'b0, 8'd0, "held_rst");
        model_cnt = 8'd0;
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 6'b0, 8'd0, "held_after_rst");
        add(1'b0, 1'b0, 6'b0, 8'd0, "held_after_rst");
        add_hold(3, "press_after_rst");

        add_press(16, "mid_long");
        add(1'b1, 1'b1, 6'b0, 8'd0, "mid_long_rst");
        model_cnt = 8'd0;
        for (int i = 0; i < 2; i++) add(1'b0, 1'b1, 6'b0, 8'd0, "mid_long_post");
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 6'b0, 8'd0, "mid_long_rel");

        for (int k = 0; k < 256; k++) add_hold(1, "wrap");

        foreach (tbl[k]) begin
            logic [13:0] exp_v, act_v;
            rst   = tbl[k].rst;
            pbreg = tbl[k].pb;
            sb.push_back({tbl[k].flags, tbl[k].cnt});
            @(posedge clk_1ms);
            #1;
            exp_v = sb.pop_front();
            act_v = {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held, press_count};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s vec %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         tbl[k].tag, k, act_v[13:8], act_v[7:0], exp_v[13:8], exp_v[7:0]);
            end
            if (tbl[k].rst && (act_v !== 14'd0)) begin
                n_err++;
                $display("FAIL reset_state %s vec %0d: outputs not cleared, flags=%b count=%0d",
                         tbl[k].tag, k, act_v[13:8], act_v[7:0]);
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("== TEST PASSED ==");
        else            $display("== TEST FAILED ==");
        $finish;
    end

endmodule
